// File: rtl/bubble_host_reader_if.sv
// Host-side bubble read bus: command/status toward the controller and the
// nBSEN/nREPEN/nBOOTEN/DOUT link toward the bubble drive emulator.
interface bubble_host_reader_if;
  logic       start_i;
  logic       boot_i;
  logic       abort_i;
  logic       dout0_i;
  logic       dout1_i;
  logic       nbsen_o;
  logic       nrepen_o;
  logic       nbooten_o;
  logic [7:0] data_o;
  logic       dvalid_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, boot_i, abort_i, dout0_i, dout1_i,
    input  nbsen_o, nrepen_o, nbooten_o, data_o, dvalid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, boot_i, abort_i, dout0_i, dout1_i,
    output nbsen_o, nrepen_o, nbooten_o, data_o, dvalid_o, busy_o, done_o
  );
endinterface

// File: rtl/bubble_host_reader.sv
// Bubble-controller host emulation: drives nBSEN/nREPEN/nBOOTEN for one page
// read per START and packs DOUT0/DOUT1 bit pairs into bytes, LSB first.
module bubble_host_reader #(
  parameter int SETUP_CYC    = 25000,
  parameter int BIT_CYC      = 960,
  parameter int REP_LOW_CYC  = 342,
  parameter int SAMPLE_OFS   = 480,
  parameter int PAGE_PERIODS = 2048
) (
  input logic                 mclk_i,
  input logic                 mrst_n_i,
  bubble_host_reader_if.slave bus
);

  localparam int SW = (SETUP_CYC    > 1) ? $clog2(SETUP_CYC)    : 1;
  localparam int CW = (BIT_CYC      > 1) ? $clog2(BIT_CYC)      : 1;
  localparam int PW = (PAGE_PERIODS > 4) ? $clog2(PAGE_PERIODS) : 2;

  localparam logic [SW-1:0] S_LAST   = SW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_REP    = CW'(REP_LOW_CYC);
  localparam logic [CW-1:0] C_SAMPLE = CW'(SAMPLE_OFS);
  localparam logic [PW-1:0] P_LAST   = PW'(PAGE_PERIODS - 1);
  localparam logic          REP_FIRST_HIGH = (REP_LOW_CYC == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  state_t        state_q;
  logic [SW-1:0] setup_q;
  logic [CW-1:0] cyc_q;
  logic [PW-1:0] per_q;
  logic [7:0]    byte_q;
  logic [7:0]    data_q;
  logic          nbsen_q;
  logic          nrepen_q;
  logic          nbooten_q;
  logic          dvalid_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    d0_sync_q;
  logic [1:0]    d1_sync_q;

  logic [7:0]    byte_d;
  logic [CW-1:0] cyc_d;
  logic          cyc_last;
  logic          rep_high_d;

  // DOUT lines come from the emulator's clock domain in real hardware.
  always_ff @(posedge mclk_i or negedge mrst_n_i) begin
    if (!mrst_n_i) begin
      d0_sync_q <= 2'b00;
      d1_sync_q <= 2'b00;
    end else begin
      d0_sync_q <= {d0_sync_q[0], bus.dout0_i};
      d1_sync_q <= {d1_sync_q[0], bus.dout1_i};
    end
  end

  always_comb begin
    byte_d = byte_q;
    byte_d[{per_q[1:0], 1'b0}] = d0_sync_q[1];
    byte_d[{per_q[1:0], 1'b1}] = d1_sync_q[1];
    cyc_last   = (cyc_q == C_LAST);
    cyc_d      = cyc_last ? '0 : cyc_q + CW'(1);
    rep_high_d = !(cyc_d < C_REP);
  end

  always_ff @(posedge mclk_i or negedge mrst_n_i) begin
    if (!mrst_n_i) begin
      state_q   <= ST_IDLE;
      setup_q   <= '0;
      cyc_q     <= '0;
      per_q     <= '0;
      byte_q    <= 8'h00;
      data_q    <= 8'h00;
      nbsen_q   <= 1'b1;
      nrepen_q  <= 1'b1;
      nbooten_q <= 1'b1;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.start_i && !bus.abort_i) begin
          state_q   <= ST_SETUP;
          setup_q   <= '0;
          nbsen_q   <= 1'b0;
          nbooten_q <= ~bus.boot_i;
          busy_q    <= 1'b1;
        end
      end else if (bus.abort_i) begin
        // Abort beats any sample in the same cycle: partial byte is dropped.
        state_q   <= ST_IDLE;
        setup_q   <= '0;
        cyc_q     <= '0;
        per_q     <= '0;
        byte_q    <= 8'h00;
        nbsen_q   <= 1'b1;
        nrepen_q  <= 1'b1;
        nbooten_q <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_SETUP: begin
            if (setup_q == S_LAST) begin
              state_q  <= ST_SHIFT;
              setup_q  <= '0;
              cyc_q    <= '0;
              per_q    <= '0;
              byte_q   <= 8'h00;
              nrepen_q <= REP_FIRST_HIGH;
            end else begin
              setup_q <= setup_q + SW'(1);
            end
          end

          ST_SHIFT: begin
            cyc_q <= cyc_d;
            if (cyc_q == C_SAMPLE) begin
              if (per_q[1:0] == 2'd3) begin
                data_q   <= byte_d;
                dvalid_q <= 1'b1;
                byte_q   <= 8'h00;
              end else begin
                byte_q <= byte_d;
              end
            end
            if (cyc_last && per_q == P_LAST) begin
              // Outputs released on entry so FINISH is the DONE cycle.
              state_q   <= ST_FINISH;
              per_q     <= '0;
              nbsen_q   <= 1'b1;
              nrepen_q  <= 1'b1;
              nbooten_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              if (cyc_last) begin
                per_q <= per_q + PW'(1);
              end
              nrepen_q <= rep_high_d;
            end
          end

          ST_FINISH: begin
            state_q <= ST_IDLE;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.nbsen_o   = nbsen_q;
  assign bus.nrepen_o  = nrepen_q;
  assign bus.nbooten_o = nbooten_q;
  assign bus.data_o    = data_q;
  assign bus.dvalid_o  = dvalid_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_bubble_host_reader.sv
// Scenario bench for bubble_host_reader: expected bytes are queued from the
// DOUT pattern as it is driven and popped when DVALID strobes.
module tb_bubble_host_reader;

  localparam int SETUP = 10;
  localparam int BITC  = 16;
  localparam int REPL  = 4;
  localparam int SOFS  = 8;
  localparam int PAGE  = 8;
  localparam int READ_LEN = SETUP + PAGE * BITC;

  logic mclk   = 1'b0;
  logic mrst_n = 1'b0;
  always #5 mclk = ~mclk;

  bubble_host_reader_if bus();

  bubble_host_reader #(
    .SETUP_CYC(SETUP), .BIT_CYC(BITC), .REP_LOW_CYC(REPL),
    .SAMPLE_OFS(SOFS), .PAGE_PERIODS(PAGE)
  ) dut (
    .mclk_i  (mclk),
    .mrst_n_i(mrst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [1:0] pat [PAGE];

  int dv_cnt, done_cnt, bsen_low, busy_cnt, boot_low, boot_mis;
  int rep_pulses, rep_badw, rep_badgap, rep_w, last_fall;
  int cyc = 0;
  logic prev_rep = 1'b1;

  // Scoreboard pop plus waveform statistics, one sample per falling edge.
  always @(negedge mclk) begin
    cyc++;
    if (bus.dvalid_o === 1'b1) begin
      dv_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dvalid_unexpected data=%h required=no strobe", bus.data_o);
      end else begin
        exp_byte = exp_q.pop_front();
        if (bus.data_o !== exp_byte) begin
          bad++;
          $display("FAIL dvalid_data got=%h required=%h", bus.data_o, exp_byte);
        end else begin
          $display("byte ok data=%h", bus.data_o);
        end
      end
    end
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.nbsen_o === 1'b0) bsen_low++;
    if (bus.busy_o === 1'b1) busy_cnt++;
    if (bus.nbooten_o === 1'b0) boot_low++;
    if (bus.nbooten_o !== bus.nbsen_o) boot_mis++;
    if (bus.nrepen_o === 1'b0) begin
      if (prev_rep) begin
        rep_pulses++;
        if (rep_pulses > 1 && cyc - last_fall != BITC) rep_badgap++;
        last_fall = cyc;
      end
      rep_w++;
    end else if (!prev_rep) begin
      if (rep_w != REPL) rep_badw++;
      rep_w = 0;
    end
    prev_rep = bus.nrepen_o;
  end

  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic clear_stats();
    dv_cnt = 0; done_cnt = 0; bsen_low = 0; busy_cnt = 0; boot_low = 0;
    boot_mis = 0; rep_pulses = 0; rep_badw = 0; rep_badgap = 0; rep_w = 0;
  endtask

  task automatic wait_rep(input logic lvl);
    int n = 0;
    while (bus.nrepen_o !== lvl && n < 200) begin
      tick();
      n++;
    end
    if (bus.nrepen_o !== lvl) begin
      total++; bad++;
      $display("FAIL wait_nrepen got=%b required=%b within 200 cycles", bus.nrepen_o, lvl);
    end
  endtask

  // Drives one read using pat[]; stops early at abort_p or rst_p (-1 = never).
  task automatic do_read(input logic boot, input int abort_p, input int start_p, input int rst_p);
    int stop_p;
    int n;
    logic [7:0] b;
    stop_p = PAGE;
    if (abort_p >= 0) stop_p = abort_p;
    if (rst_p >= 0) stop_p = rst_p;
    for (int i = 0; i < PAGE / 4; i++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++) begin
        b[2*k]   = pat[4*i+k][0];
        b[2*k+1] = pat[4*i+k][1];
      end
      if (4 * i + 3 < stop_p) exp_q.push_back(b);
    end
    tick();
    clear_stats();
    bus.start_i = 1'b1;
    bus.boot_i  = boot;
    tick();
    bus.start_i = 1'b0;
    bus.boot_i  = 1'b0;
    for (int p = 0; p < PAGE; p++) begin
      wait_rep(1'b0);
      {bus.dout1_i, bus.dout0_i} = pat[p];
      if (p == start_p) begin
        tick(); bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
      end
      if (p == abort_p) begin
        tick(); tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        return;
      end
      if (p == rst_p) begin
        tick();
        #2 mrst_n = 1'b0;
        return;
      end
      wait_rep(1'b1);
    end
    n = 0;
    while (bus.busy_o !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    mrst_n = 1'b0;
    tick(); tick(); tick();
    mrst_n = 1'b1;
    repeat (20) tick();
    total += 7;
    if (bus.nbsen_o   !== 1'b1)  begin bad++; $display("FAIL reset_nbsen got=%b required=1", bus.nbsen_o); end
    if (bus.nrepen_o  !== 1'b1)  begin bad++; $display("FAIL reset_nrepen got=%b required=1", bus.nrepen_o); end
    if (bus.nbooten_o !== 1'b1)  begin bad++; $display("FAIL reset_nbooten got=%b required=1", bus.nbooten_o); end
    if (bus.busy_o    !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b required=0", bus.busy_o); end
    if (bus.dvalid_o  !== 1'b0)  begin bad++; $display("FAIL reset_dvalid got=%b required=0", bus.dvalid_o); end
    if (bus.done_o    !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b required=0", bus.done_o); end
    if (bus.data_o    !== 8'h00) begin bad++; $display("FAIL reset_data got=%h required=00", bus.data_o); end
    $display("test_reset checked");
  endtask

  task automatic test_page_read();
    for (int i = 0; i < PAGE; i++) pat[i] = 2'b01;
    do_read(1'b0, -1, -1, -1);
    total += 9;
    if (bsen_low   !== READ_LEN) begin bad++; $display("FAIL page_nbsen_low got=%0d required=%0d", bsen_low, READ_LEN); end
    if (busy_cnt   !== READ_LEN) begin bad++; $display("FAIL page_busy_len got=%0d required=%0d", busy_cnt, READ_LEN); end
    if (rep_pulses !== PAGE)     begin bad++; $display("FAIL page_rep_pulses got=%0d required=%0d", rep_pulses, PAGE); end
    if (rep_badw   !== 0)        begin bad++; $display("FAIL page_rep_width bad=%0d required=0", rep_badw); end
    if (rep_badgap !== 0)        begin bad++; $display("FAIL page_rep_gap bad=%0d required=0", rep_badgap); end
    if (boot_low   !== 0)        begin bad++; $display("FAIL page_nbooten_low got=%0d required=0", boot_low); end
    if (dv_cnt     !== PAGE / 4) begin bad++; $display("FAIL page_dvalid_cnt got=%0d required=%0d", dv_cnt, PAGE / 4); end
    if (done_cnt   !== 1)        begin bad++; $display("FAIL page_done_cnt got=%0d required=1", done_cnt); end
    if (exp_q.size() !== 0)      begin bad++; $display("FAIL page_left_in_queue got=%0d required=0", exp_q.size()); end
    $display("test_page_read checked");
  endtask

  task automatic test_bit_order();
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;
    pat[4] = 2'b00; pat[5] = 2'b00; pat[6] = 2'b00; pat[7] = 2'b11;
    do_read(1'b0, -1, -1, -1);
    total += 3;
    if (dv_cnt      !== 2)     begin bad++; $display("FAIL order_dvalid_cnt got=%0d required=2", dv_cnt); end
    if (bus.data_o  !== 8'hC0) begin bad++; $display("FAIL order_data_hold got=%h required=c0", bus.data_o); end
    if (exp_q.size() !== 0)    begin bad++; $display("FAIL order_left_in_queue got=%0d required=0", exp_q.size()); end
    $display("test_bit_order checked");
  endtask

  task automatic test_bootloop();
    for (int i = 0; i < PAGE; i++) pat[i] = 2'(i);
    do_read(1'b1, -1, -1, -1);
    total += 4;
    if (boot_low !== READ_LEN) begin bad++; $display("FAIL boot_low_len got=%0d required=%0d", boot_low, READ_LEN); end
    if (boot_mis !== 0)        begin bad++; $display("FAIL boot_vs_nbsen mismatched_cycles=%0d required=0", boot_mis); end
    if (done_cnt !== 1)        begin bad++; $display("FAIL boot_done_cnt got=%0d required=1", done_cnt); end
    if (dv_cnt   !== 2)        begin bad++; $display("FAIL boot_dvalid_cnt got=%0d required=2", dv_cnt); end
    $display("test_bootloop checked");
  endtask

  task automatic test_abort();
    for (int i = 0; i < PAGE; i++) pat[i] = 2'b11;
    do_read(1'b1, 5, -1, -1);
    total += 4;
    if (bus.nbsen_o   !== 1'b1) begin bad++; $display("FAIL abort_nbsen got=%b required=1", bus.nbsen_o); end
    if (bus.nrepen_o  !== 1'b1) begin bad++; $display("FAIL abort_nrepen got=%b required=1", bus.nrepen_o); end
    if (bus.nbooten_o !== 1'b1) begin bad++; $display("FAIL abort_nbooten got=%b required=1", bus.nbooten_o); end
    if (bus.busy_o    !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b required=0", bus.busy_o); end
    repeat (3 * BITC) tick();
    total += 3;
    if (done_cnt !== 0)     begin bad++; $display("FAIL abort_done_cnt got=%0d required=0", done_cnt); end
    if (dv_cnt   !== 1)     begin bad++; $display("FAIL abort_dvalid_cnt got=%0d required=1", dv_cnt); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL abort_left_in_queue got=%0d required=0", exp_q.size()); end
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b00; pat[3] = 2'b11;
    pat[4] = 2'b11; pat[5] = 2'b10; pat[6] = 2'b01; pat[7] = 2'b00;
    do_read(1'b0, -1, -1, -1);
    total += 3;
    if (bsen_low !== READ_LEN) begin bad++; $display("FAIL after_abort_nbsen_low got=%0d required=%0d", bsen_low, READ_LEN); end
    if (dv_cnt   !== 2)        begin bad++; $display("FAIL after_abort_dvalid_cnt got=%0d required=2", dv_cnt); end
    if (done_cnt !== 1)        begin bad++; $display("FAIL after_abort_done_cnt got=%0d required=1", done_cnt); end
    $display("test_abort checked");
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < PAGE; i++) pat[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
    do_read(1'b0, -1, 3, -1);
    total += 5;
    if (bsen_low   !== READ_LEN) begin bad++; $display("FAIL istart_nbsen_low got=%0d required=%0d", bsen_low, READ_LEN); end
    if (busy_cnt   !== READ_LEN) begin bad++; $display("FAIL istart_busy_len got=%0d required=%0d", busy_cnt, READ_LEN); end
    if (rep_badgap !== 0)        begin bad++; $display("FAIL istart_rep_gap bad=%0d required=0", rep_badgap); end
    if (done_cnt   !== 1)        begin bad++; $display("FAIL istart_done_cnt got=%0d required=1", done_cnt); end
    if (dv_cnt     !== 2)        begin bad++; $display("FAIL istart_dvalid_cnt got=%0d required=2", dv_cnt); end
    $display("test_ignored_start checked");
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < PAGE; i++) pat[i] = 2'b01;
    do_read(1'b1, -1, -1, 5);
    #1;
    total += 6;
    if (bus.nbsen_o   !== 1'b1)  begin bad++; $display("FAIL mrst_nbsen got=%b required=1", bus.nbsen_o); end
    if (bus.nrepen_o  !== 1'b1)  begin bad++; $display("FAIL mrst_nrepen got=%b required=1", bus.nrepen_o); end
    if (bus.nbooten_o !== 1'b1)  begin bad++; $display("FAIL mrst_nbooten got=%b required=1", bus.nbooten_o); end
    if (bus.busy_o    !== 1'b0)  begin bad++; $display("FAIL mrst_busy got=%b required=0", bus.busy_o); end
    if (bus.dvalid_o  !== 1'b0)  begin bad++; $display("FAIL mrst_dvalid got=%b required=0", bus.dvalid_o); end
    if (bus.data_o    !== 8'h00) begin bad++; $display("FAIL mrst_data got=%h required=00", bus.data_o); end
    repeat (5) tick();
    mrst_n = 1'b1;
    repeat (3 * BITC) tick();
    total += 3;
    if (done_cnt !== 0)     begin bad++; $display("FAIL mrst_done_cnt got=%0d required=0", done_cnt); end
    if (dv_cnt   !== 1)     begin bad++; $display("FAIL mrst_dvalid_cnt got=%0d required=1", dv_cnt); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL mrst_left_in_queue got=%0d required=0", exp_q.size()); end
    $display("test_reset_mid_read checked");
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.boot_i  = 1'b0;
    bus.abort_i = 1'b0;
    bus.dout0_i = 1'b0;
    bus.dout1_i = 1'b0;
    clear_stats();
    test_reset();
    test_page_read();
    test_bit_order();
    test_bootloop();
    test_abort();
    test_ignored_start();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
